// File: rtl/eeprom_rw_check.sv
// EEPROM self-test: writes an index pattern, waits out tWR,
// reads it back and reports a sticky pass/fail to the alarm stage.
module eeprom_rw_check #(
    parameter int          BYTE_NUM   = 8,
    parameter logic [15:0] START_ADDR = 16'h0000,
    parameter int          PWR_WAIT   = 25_000_000,
    parameter int          TWR_WAIT   = 250_000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        i2c_exec,
    output logic        i2c_rh_wl,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    input  logic [7:0]  i2c_data_r,
    output logic        rw_done,
    output logic        rw_result
);

    localparam int MAX_WAIT =
        (PWR_WAIT > TWR_WAIT) ? PWR_WAIT : TWR_WAIT;
    localparam int CW =
        (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] PWR_LAST = CW'(PWR_WAIT - 1);
    localparam logic [CW-1:0] TWR_LAST = CW'(TWR_WAIT - 1);
    localparam logic [8:0]    K_LAST   = 9'(BYTE_NUM - 1);

    typedef enum logic [2:0] {
        PWR,
        WR_REQ,
        WR_WAIT,
        TWR,
        RD_REQ,
        RD_WAIT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [8:0]    k;
    logic          err;

    logic pwr_end;
    logic twr_end;
    logic last_byte;
    logic rd_bad;

    assign pwr_end   = (cnt == PWR_LAST);
    assign twr_end   = (cnt == TWR_LAST);
    assign last_byte = (k == K_LAST);
    // A read is bad on NACK or on a data miscompare.
    assign rd_bad    = i2c_ack | (i2c_data_r != k[7:0]);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PWR;
        else     state <= state_nxt;
    end

    // Next-state: REQ states last one cycle, WAIT states hold for done.
    always_comb begin
        state_nxt = state;
        unique case (state)
            PWR:     if (pwr_end) state_nxt = WR_REQ;
            WR_REQ:  state_nxt = WR_WAIT;
            WR_WAIT: if (i2c_done)
                         state_nxt = last_byte ? TWR : WR_REQ;
            TWR:     if (twr_end) state_nxt = RD_REQ;
            RD_REQ:  state_nxt = RD_WAIT;
            RD_WAIT: if (i2c_done)
                         state_nxt = last_byte ? DONE : RD_REQ;
            DONE:    state_nxt = DONE;
            default: state_nxt = PWR;
        endcase
    end

    // Counters, sticky error and registered driver/result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            k          <= '0;
            err        <= 1'b0;
            i2c_exec   <= 1'b0;
            i2c_rh_wl  <= 1'b0;
            i2c_addr   <= START_ADDR;
            i2c_data_w <= 8'h00;
            rw_done    <= 1'b0;
            rw_result  <= 1'b0;
        end else begin
            i2c_exec <= 1'b0;
            unique case (state)
                PWR: begin
                    cnt <= pwr_end ? '0 : cnt + 1'b1;
                end
                WR_REQ: begin
                    i2c_exec   <= 1'b1;
                    i2c_rh_wl  <= 1'b0;
                    i2c_addr   <= START_ADDR + {7'd0, k};
                    i2c_data_w <= k[7:0];
                end
                WR_WAIT: begin
                    if (i2c_done) begin
                        err <= err | i2c_ack;
                        k   <= k + 1'b1;
                    end
                end
                TWR: begin
                    cnt <= twr_end ? '0 : cnt + 1'b1;
                    if (twr_end) k <= '0;
                end
                RD_REQ: begin
                    i2c_exec  <= 1'b1;
                    i2c_rh_wl <= 1'b1;
                    i2c_addr  <= START_ADDR + {7'd0, k};
                end
                RD_WAIT: begin
                    if (i2c_done) begin
                        err <= err | rd_bad;
                        k   <= k + 1'b1;
                        if (last_byte) begin
                            rw_done   <= 1'b1;
                            rw_result <= ~(err | rd_bad);
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_rw_check.sv
// Self-checking bench for eeprom_rw_check: I2C driver/EEPROM model,
// timing monitor and scenario tasks against a sequence-level model.
module tb_eeprom_rw_check;

    localparam int PW  = 10;
    localparam int TW  = 20;
    localparam int BN  = 4;
    localparam int LAT = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, sel;
    logic done, ack;
    logic [7:0] data_r;

    logic exec0, rw0, rwd0, rwr0;
    logic exec1, rw1, rwd1, rwr1;
    logic [15:0] addr0, addr1;
    logic [7:0]  dw0, dw1;

    eeprom_rw_check #(
        .BYTE_NUM(BN), .START_ADDR(16'h0000),
        .PWR_WAIT(PW), .TWR_WAIT(TW)
    ) u_dut0 (
        .clk(clk), .rst(rst0),
        .i2c_exec(exec0), .i2c_rh_wl(rw0),
        .i2c_addr(addr0), .i2c_data_w(dw0),
        .i2c_done(done), .i2c_ack(ack),
        .i2c_data_r(data_r),
        .rw_done(rwd0), .rw_result(rwr0)
    );

    eeprom_rw_check #(
        .BYTE_NUM(BN), .START_ADDR(16'hFFFE),
        .PWR_WAIT(PW), .TWR_WAIT(TW)
    ) u_dut1 (
        .clk(clk), .rst(rst1),
        .i2c_exec(exec1), .i2c_rh_wl(rw1),
        .i2c_addr(addr1), .i2c_data_w(dw1),
        .i2c_done(done), .i2c_ack(ack),
        .i2c_data_r(data_r),
        .rw_done(rwd1), .rw_result(rwr1)
    );

    logic m_exec, m_rw, m_rwd, m_rwr, m_rst;
    logic [15:0] m_addr, base;
    logic [7:0]  m_dw;
    assign m_exec = sel ? exec1 : exec0;
    assign m_rw   = sel ? rw1   : rw0;
    assign m_addr = sel ? addr1 : addr0;
    assign m_dw   = sel ? dw1   : dw0;
    assign m_rwd  = sel ? rwd1  : rwd0;
    assign m_rwr  = sel ? rwr1  : rwr0;
    assign m_rst  = sel ? rst1  : rst0;
    assign base   = sel ? 16'hFFFE : 16'h0000;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // fault configuration (written by scenario tasks only)
    bit       nack_wr [BN];
    bit       nack_rd [BN];
    bit       bad_rd  [BN];
    bit [7:0] bad_val [BN];
    bit       spur_en;
    int       run_id = 0;
    int       rel_cyc = 0;

    // driver/monitor state (written by the driver process only)
    logic [7:0]  mem [0:65535];
    bit          lg_rw [$];
    logic [15:0] lg_addr [$];
    logic [7:0]  lg_data [$];
    int          lg_gap [$];
    int seen_id = 0;
    bit busy;
    int timer;
    bit cur_rw;
    logic [15:0] cur_addr;
    logic [7:0]  cur_dw;
    int wr_cnt, rd_cnt, ref_cyc, last_rd_cyc, rwd_cyc;
    bit rwd_res, prev_exec, prev_rwd;
    int width_err, stab_err, tog_err, ovl_err;

    // I2C driver + EEPROM model + protocol monitor, on the falling edge.
    always @(negedge clk) begin
        done = 1'b0;
        ack  = 1'b0;
        if (m_rst) begin
            busy = 0;
            prev_exec = 0;
            prev_rwd = 0;
            if (seen_id != run_id) begin
                seen_id = run_id;
                lg_rw.delete(); lg_addr.delete();
                lg_data.delete(); lg_gap.delete();
                wr_cnt = 0; rd_cnt = 0;
                last_rd_cyc = -1; rwd_cyc = -1; rwd_res = 0;
                width_err = 0; stab_err = 0;
                tog_err = 0; ovl_err = 0;
                for (int j = 0; j < BN; j++)
                    mem[base + 16'(j)] = ~8'(j);
            end
        end else begin
            if (m_exec && prev_exec) width_err++;
            if (busy && (m_rw !== cur_rw || m_addr !== cur_addr ||
                         m_dw !== cur_dw))
                stab_err++;
            if (m_exec && !prev_exec) begin
                if (busy) ovl_err++;
                busy = 1; timer = LAT;
                cur_rw = m_rw; cur_addr = m_addr; cur_dw = m_dw;
                lg_rw.push_back(m_rw);
                lg_addr.push_back(m_addr);
                lg_data.push_back(m_dw);
                lg_gap.push_back(lg_addr.size() == 1 ?
                                 cyc - rel_cyc : cyc - ref_cyc);
            end else if (busy) begin
                timer--;
                if (timer == 0) begin
                    busy = 0; done = 1'b1; ref_cyc = cyc;
                    if (!cur_rw) begin
                        if (wr_cnt < BN) ack = nack_wr[wr_cnt];
                        mem[cur_addr] = cur_dw;
                        wr_cnt++;
                    end else begin
                        if (rd_cnt < BN) begin
                            ack = nack_rd[rd_cnt];
                            data_r = bad_rd[rd_cnt] ?
                                     bad_val[rd_cnt] : mem[cur_addr];
                        end else data_r = mem[cur_addr];
                        rd_cnt++;
                        last_rd_cyc = cyc;
                    end
                end
            end else if (spur_en) begin
                if (lg_addr.size() == 0 && cyc - rel_cyc == 4) begin
                    done = 1'b1; ack = 1'b1; data_r = 8'h5A;
                end
                if (lg_addr.size() == BN && wr_cnt == BN &&
                    cyc - ref_cyc == 6) begin
                    done = 1'b1; ack = 1'b1; data_r = 8'hA5;
                end
            end
            if (m_rwd && !prev_rwd) begin
                rwd_cyc = cyc; rwd_res = m_rwr;
            end
            if (prev_rwd && (m_rwd !== 1'b1 || m_rwr !== rwd_res))
                tog_err++;
            prev_exec = m_exec;
            prev_rwd  = m_rwd;
        end
    end

    function automatic int exp_gap(input int i);
        if (i == 0)  return PW + 1;
        if (i == BN) return TW + 2;
        return 2;
    endfunction

    // sequence-level model: pass iff every ack clean and readback == k
    function automatic bit exp_pass();
        bit p = 1;
        for (int j = 0; j < BN; j++) begin
            if (nack_wr[j] || nack_rd[j]) p = 0;
            if (bad_rd[j] && bad_val[j] != 8'(j)) p = 0;
        end
        return p;
    endfunction

    task automatic clear_faults();
        for (int j = 0; j < BN; j++) begin
            nack_wr[j] = 0; nack_rd[j] = 0;
            bad_rd[j] = 0; bad_val[j] = 8'h00;
        end
        spur_en = 0;
    endtask

    task automatic start_run(input bit s);
        @(negedge clk); #1;
        rst0 = 1'b1; rst1 = 1'b1; sel = s;
        run_id++;
        repeat (3) @(negedge clk);
        #1;
        rel_cyc = cyc;
        if (s) rst1 = 1'b0;
        else   rst0 = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (m_rwd === 1'b1) begin to = 0; break; end
        end
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; sel = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({exec0, rw0, dw0, rwd0, rwr0} !== 12'h000) begin
            errors++;
            $display("FAIL reset0 outs: got %b%b %h %b%b want 00 00 00",
                     exec0, rw0, dw0, rwd0, rwr0);
        end
        checks++;
        if (addr0 !== 16'h0000) begin
            errors++;
            $display("FAIL reset0 addr: got %h want 0000", addr0);
        end
        checks++;
        if ({exec1, rw1, dw1, rwd1, rwr1} !== 12'h000) begin
            errors++;
            $display("FAIL reset1 outs: got %b%b %h %b%b want 00 00 00",
                     exec1, rw1, dw1, rwd1, rwr1);
        end
        checks++;
        if (addr1 !== 16'hFFFE) begin
            errors++;
            $display("FAIL reset1 addr: got %h want fffe", addr1);
        end
    endtask

    task automatic check_seq(input string nm);
        checks++;
        if (lg_addr.size() != 2 * BN) begin
            errors++;
            $display("FAIL %s count: got %0d accesses want %0d",
                     nm, lg_addr.size(), 2 * BN);
        end
        for (int i = 0; i < 2 * BN && i < lg_addr.size(); i++) begin
            logic [15:0] ea;
            ea = base + 16'(i % BN);
            checks++;
            if (lg_rw[i] !== (i >= BN) || lg_addr[i] !== ea ||
                (i < BN && lg_data[i] !== 8'(i)) ||
                lg_gap[i] != exp_gap(i)) begin
                errors++;
                $display("FAIL %s acc%0d: got rw=%b a=%h d=%h gap=%0d want rw=%b a=%h d=%h gap=%0d",
                         nm, i, lg_rw[i], lg_addr[i], lg_data[i],
                         lg_gap[i], (i >= BN), ea, 8'(i % BN),
                         exp_gap(i));
            end
        end
    endtask

    task automatic check_end(input string nm, input bit to,
                             input bit res);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s timeout: rw_done never rose", nm);
        end
        checks++;
        if (wr_cnt != BN || rd_cnt != BN) begin
            errors++;
            $display("FAIL %s ops: got wr=%0d rd=%0d want %0d/%0d",
                     nm, wr_cnt, rd_cnt, BN, BN);
        end
        checks++;
        if (rwd_res !== res) begin
            errors++;
            $display("FAIL %s result: got %b want %b", nm, rwd_res, res);
        end
        checks++;
        if (rwd_cyc - last_rd_cyc != 1) begin
            errors++;
            $display("FAIL %s done lat: got %0d want 1",
                     nm, rwd_cyc - last_rd_cyc);
        end
        checks++;
        if (width_err + stab_err + tog_err + ovl_err != 0) begin
            errors++;
            $display("FAIL %s proto: got w=%0d s=%0d t=%0d o=%0d want 0",
                     nm, width_err, stab_err, tog_err, ovl_err);
        end
    endtask

    task automatic test_clean_pass();
        bit to;
        clear_faults();
        start_run(0);
        wait_done(to);
        check_end("clean", to, 1'b1);
        check_seq("clean");
    endtask

    task automatic test_mismatch();
        bit to;
        clear_faults();
        bad_rd[2] = 1; bad_val[2] = 8'hFF;
        start_run(0);
        wait_done(to);
        check_end("mismatch", to, 1'b0);
    endtask

    task automatic test_nack();
        bit to;
        clear_faults();
        nack_wr[1] = 1;
        start_run(0);
        wait_done(to);
        check_end("nack", to, 1'b0);
    endtask

    task automatic test_wrap();
        bit to;
        clear_faults();
        start_run(1);
        wait_done(to);
        check_end("wrap", to, 1'b1);
        check_seq("wrap");
    endtask

    task automatic test_reset_mid_read();
        bit to, hit;
        clear_faults();
        start_run(0);
        hit = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (lg_addr.size() == BN + 2 && busy) begin
                hit = 1; break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midrd reach: 2nd read never outstanding");
        end
        repeat (5) @(negedge clk);
        #1;
        rst0 = 1'b1;
        run_id++;
        #1;
        checks++;
        if (exec0 !== 1'b0 || rwd0 !== 1'b0 || addr0 !== 16'h0000) begin
            errors++;
            $display("FAIL midrd rst: got exec=%b done=%b a=%h want 0 0 0000",
                     exec0, rwd0, addr0);
        end
        repeat (3) @(negedge clk);
        #1;
        rel_cyc = cyc;
        rst0 = 1'b0;
        wait_done(to);
        check_end("midrd", to, 1'b1);
        check_seq("midrd");
    endtask

    task automatic test_spurious();
        bit to;
        clear_faults();
        spur_en = 1;
        start_run(0);
        wait_done(to);
        check_end("spur", to, 1'b1);
        check_seq("spur");
        spur_en = 0;
    endtask

    task automatic test_random();
        bit to, s, ep;
        for (int it = 0; it < 6; it++) begin
            clear_faults();
            for (int j = 0; j < BN; j++) begin
                nack_wr[j] = ($urandom_range(0, 5) == 0);
                nack_rd[j] = ($urandom_range(0, 5) == 0);
                bad_rd[j]  = ($urandom_range(0, 3) == 0);
                bad_val[j] = 8'(j) ^ 8'($urandom_range(1, 255));
            end
            s  = 1'($urandom_range(0, 1));
            ep = exp_pass();
            start_run(s);
            wait_done(to);
            check_end($sformatf("rand%0d", it), to, ep);
        end
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; sel = 1'b0;
        clear_faults();
        test_reset();
        test_clean_pass();
        test_mismatch();
        test_nack();
        test_wrap();
        test_reset_mid_read();
        test_spurious();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
